// File: rtl/sj_video_timing_gen.sv
// Video timing generator: H/V pixel counters, blanking/sync decode, pixel-phase shifter,
// scroll-load strobes, VBL interrupt, line-compare pulse and frame counter.
module sj_video_timing_gen #(
  parameter logic [8:0]  H_START    = 9'd128,
  parameter logic [8:0]  H_END      = 9'd511,
  parameter logic [8:0]  H_ACTIVE   = 9'd256,
  parameter logic [8:0]  H_SYNC_ON  = 9'd160,
  parameter logic [8:0]  H_SYNC_OFF = 9'd192,
  parameter logic [8:0]  H_VINC     = 9'd496,
  parameter logic [8:0]  V_START    = 9'd248,
  parameter logic [8:0]  V_END      = 9'd511,
  parameter logic [8:0]  V_BL_ON    = 9'd496,
  parameter logic [8:0]  V_BL_OFF   = 9'd272,
  parameter logic [8:0]  V_SYNC_ON  = 9'd256,
  parameter logic [8:0]  V_SYNC_OFF = 9'd511,
  parameter int unsigned PH_LEN     = 8,
  parameter int unsigned NUM_SCROLL = 3,
  parameter int unsigned SCROLL_W   = 3
) (
  input  logic                  clkm_48MHZ,
  input  logic                  RESET_n,
  input  logic                  pix_ce,
  input  logic                  HINV,
  input  logic                  VINV,
  input  logic [7:0]            Z80A_DATABUS,
  input  logic [NUM_SCROLL-1:0] scroll_wr,
  input  logic [8:0]            line_cmp,
  output logic [8:0]            SB_HN,
  output logic [7:0]            SB_H,
  output logic [7:0]            SB_V,
  output logic [PH_LEN-1:0]     PH,
  output logic                  HBL,
  output logic                  VBL,
  output logic                  BLANK,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic [NUM_SCROLL-1:0] SNLD,
  output logic                  vbl_irq,
  output logic                  line_hit,
  output logic [7:0]            frame_cnt
);

  logic [8:0]                               hpix_q, hpix_d;
  logic [8:0]                               vpix_q, vpix_d;
  logic                                     vadv;
  logic [PH_LEN-1:0]                        ph_q, ph_d;
  logic                                     vbl_q, vbl_d;
  logic                                     vbl_prev_q;
  logic                                     vload_q;
  logic [NUM_SCROLL-1:0][SCROLL_W-1:0]      latch_q, latch_d;
  logic [NUM_SCROLL-1:0]                    snld_q, snld_d;
  logic                                     vbl_irq_q;
  logic                                     line_hit_q;
  logic [7:0]                               frame_q, frame_d;

  always_comb begin
    hpix_d  = hpix_q;
    vpix_d  = vpix_q;
    vadv    = 1'b0;
    ph_d    = ph_q;
    vbl_d   = vbl_q;
    frame_d = frame_q;
    snld_d  = snld_q;

    if (pix_ce) begin
      hpix_d = (hpix_q == H_END) ? H_START : hpix_q + 9'd1;
      ph_d   = {ph_q[PH_LEN-2:0], ~(hpix_q[2] & hpix_q[1])};
      if (hpix_q == H_VINC) begin
        vadv = 1'b1;
        if (vpix_q == V_END) begin
          vpix_d  = V_START;
          frame_d = frame_q + 8'd1;
        end else begin
          vpix_d = vpix_q + 9'd1;
        end
      end
      // Compare against the latch value held before any write in this same clock.
      for (int i = 0; i < int'(NUM_SCROLL); i++) begin
        snld_d[i] = (latch_q[i] != hpix_d[SCROLL_W-1:0]);
      end
    end

    // Set has priority so equal on/off lines leave VBL asserted.
    if (vadv) begin
      if (vpix_d == V_BL_ON) begin
        vbl_d = 1'b1;
      end else if (vpix_d == V_BL_OFF) begin
        vbl_d = 1'b0;
      end
    end

    for (int i = 0; i < int'(NUM_SCROLL); i++) begin
      latch_d[i] = scroll_wr[i] ? Z80A_DATABUS[SCROLL_W-1:0] : latch_q[i];
    end
  end

  always_ff @(posedge clkm_48MHZ or negedge RESET_n) begin
    if (!RESET_n) begin
      hpix_q     <= H_START;
      vpix_q     <= V_START;
      ph_q       <= '0;
      vbl_q      <= 1'b0;
      vbl_prev_q <= 1'b0;
      vload_q    <= 1'b0;
      latch_q    <= '0;
      snld_q     <= '0;
      vbl_irq_q  <= 1'b0;
      line_hit_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      hpix_q     <= hpix_d;
      vpix_q     <= vpix_d;
      ph_q       <= ph_d;
      vbl_q      <= vbl_d;
      vbl_prev_q <= vbl_q;
      vload_q    <= vadv;
      latch_q    <= latch_d;
      snld_q     <= snld_d;
      frame_q    <= frame_d;
      vbl_irq_q  <= vbl_q & ~vbl_prev_q;
      // Only a freshly loaded line can hit, so a mid-line line_cmp change never pulses.
      line_hit_q <= vload_q & (vpix_q == line_cmp);
    end
  end

  logic [9:0] hpix_x, vpix_x;
  assign hpix_x = {1'b0, hpix_q};
  assign vpix_x = {1'b0, vpix_q};

  assign SB_HN     = hpix_q;
  assign SB_H      = hpix_q[7:0] ^ {8{HINV}};
  assign SB_V      = vpix_q[7:0] ^ {8{VINV}};
  assign PH        = ph_q;
  assign HBL       = (hpix_q < H_ACTIVE);
  assign VBL       = vbl_q;
  assign BLANK     = HBL | vbl_q;
  assign HSYNC     = (hpix_x >= {1'b0, H_SYNC_ON}) && (hpix_x <= {1'b0, H_SYNC_OFF});
  assign VSYNC     = (vpix_x >= {1'b0, V_SYNC_ON}) && (vpix_x <= {1'b0, V_SYNC_OFF});
  assign SNLD      = snld_q;
  assign vbl_irq   = vbl_irq_q;
  assign line_hit  = line_hit_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_sj_video_timing_gen.sv
// Bench for sj_video_timing_gen: shortened frame geometry, positional reference model
// derived from the total pixel count, plus table vectors and hand-written corner sequences.
module tb_sj_video_timing_gen;

  localparam logic [8:0] H_START    = 9'd128;
  localparam logic [8:0] H_END      = 9'd511;
  localparam logic [8:0] H_ACTIVE   = 9'd256;
  localparam logic [8:0] H_SYNC_ON  = 9'd160;
  localparam logic [8:0] H_SYNC_OFF = 9'd192;
  localparam logic [8:0] H_VINC     = 9'd496;
  localparam logic [8:0] V_START    = 9'd266;
  localparam logic [8:0] V_END      = 9'd301;
  localparam logic [8:0] V_BL_ON    = 9'd296;
  localparam logic [8:0] V_BL_OFF   = 9'd272;
  localparam logic [8:0] V_SYNC_ON  = 9'd268;
  localparam logic [8:0] V_SYNC_OFF = 9'd280;
  localparam int HLEN = int'(H_END) - int'(H_START) + 1;
  localparam int VLEN = int'(V_END) - int'(V_START) + 1;

  logic       clk;
  logic       RESET_n;
  logic       pix_ce;
  logic       HINV;
  logic       VINV;
  logic [7:0] Z80A_DATABUS;
  logic [2:0] scroll_wr;
  logic [8:0] line_cmp;
  logic [8:0] SB_HN;
  logic [7:0] SB_H;
  logic [7:0] SB_V;
  logic [7:0] PH;
  logic       HBL, VBL, BLANK, HSYNC, VSYNC;
  logic [2:0] SNLD;
  logic       vbl_irq;
  logic       line_hit;
  logic [7:0] frame_cnt;

  sj_video_timing_gen #(
    .H_START(H_START), .H_END(H_END), .H_ACTIVE(H_ACTIVE), .H_SYNC_ON(H_SYNC_ON),
    .H_SYNC_OFF(H_SYNC_OFF), .H_VINC(H_VINC), .V_START(V_START), .V_END(V_END),
    .V_BL_ON(V_BL_ON), .V_BL_OFF(V_BL_OFF), .V_SYNC_ON(V_SYNC_ON), .V_SYNC_OFF(V_SYNC_OFF),
    .PH_LEN(8), .NUM_SCROLL(3), .SCROLL_W(3)
  ) dut (
    .clkm_48MHZ(clk), .RESET_n(RESET_n), .pix_ce(pix_ce), .HINV(HINV), .VINV(VINV),
    .Z80A_DATABUS(Z80A_DATABUS), .scroll_wr(scroll_wr), .line_cmp(line_cmp),
    .SB_HN(SB_HN), .SB_H(SB_H), .SB_V(SB_V), .PH(PH), .HBL(HBL), .VBL(VBL), .BLANK(BLANK),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .SNLD(SNLD), .vbl_irq(vbl_irq), .line_hit(line_hit),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [50:0] dut_vec;
  assign dut_vec = {SB_HN, SB_H, SB_V, PH, HBL, VBL, BLANK, HSYNC, VSYNC, SNLD, vbl_irq,
                    line_hit, frame_cnt};

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: pixel count since reset plus a few event flags.
  int         m_n;
  logic [2:0] m_latch [3];
  logic [2:0] m_snld;
  logic       m_irq, m_hit, m_vload, m_vbl_prev;

  function automatic int vadv_of(input int n);
    return (n + int'(H_END) - int'(H_VINC)) / HLEN;
  endfunction

  function automatic logic [8:0] h_of(input int n);
    return 9'(int'(H_START) + n % HLEN);
  endfunction

  function automatic logic [8:0] v_of(input int n);
    return 9'(int'(V_START) + vadv_of(n) % VLEN);
  endfunction

  function automatic logic [7:0] frame_of(input int n);
    return 8'((vadv_of(n) / VLEN) % 256);
  endfunction

  // Blanked from V_BL_ON to the end of the frame and, once a wrap has happened,
  // from the frame start up to V_BL_OFF.
  function automatic logic vbl_of(input int n);
    logic [8:0] v;
    v = v_of(n);
    return (v >= V_BL_ON) || ((v < V_BL_OFF) && (vadv_of(n) >= VLEN));
  endfunction

  function automatic logic [7:0] ph_of(input int n);
    logic [7:0] r;
    logic [8:0] hk;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (n - 1 - j >= 0) begin
        hk   = h_of(n - 1 - j);
        r[j] = ~(hk[2] & hk[1]);
      end
    end
    return r;
  endfunction

  function automatic logic [50:0] exp_vec();
    logic [8:0] h, v;
    logic       hbl, vb;
    h   = h_of(m_n);
    v   = v_of(m_n);
    hbl = (h < H_ACTIVE);
    vb  = vbl_of(m_n);
    return {h, h[7:0] ^ {8{HINV}}, v[7:0] ^ {8{VINV}}, ph_of(m_n), hbl, vb, hbl | vb,
            (h >= H_SYNC_ON) && (h <= H_SYNC_OFF), (v >= V_SYNC_ON) && (v <= V_SYNC_OFF),
            m_snld, m_irq, m_hit, frame_of(m_n)};
  endfunction

  task automatic model_reset();
    m_n = 0;
    for (int i = 0; i < 3; i++) m_latch[i] = '0;
    m_snld     = '0;
    m_irq      = 1'b0;
    m_hit      = 1'b0;
    m_vload    = 1'b0;
    m_vbl_prev = 1'b0;
  endtask

  task automatic model_edge(input logic pce, input logic [2:0] wr, input logic [7:0] data);
    logic       vb;
    logic [8:0] hn;
    vb         = vbl_of(m_n);
    m_irq      = vb && !m_vbl_prev;
    m_vbl_prev = vb;
    m_hit      = m_vload && (v_of(m_n) == line_cmp);
    m_vload    = pce && (vadv_of(m_n + 1) != vadv_of(m_n));
    if (pce) begin
      hn = h_of(m_n + 1);
      for (int i = 0; i < 3; i++) m_snld[i] = (m_latch[i] != hn[2:0]);
      m_n++;
    end
    for (int i = 0; i < 3; i++) if (wr[i]) m_latch[i] = data[2:0];
  endtask

  task automatic check(input string name, input logic [50:0] got, input logic [50:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input logic pce, input logic [2:0] wr, input logic [7:0] data);
    pix_ce       = pce;
    scroll_wr    = wr;
    Z80A_DATABUS = data;
    @(posedge clk);
    model_edge(pce, wr, data);
    @(negedge clk);
    check("tick", dut_vec, exp_vec());
  endtask

  task automatic do_reset();
    RESET_n   = 1'b0;
    pix_ce    = 1'b0;
    scroll_wr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    RESET_n = 1'b1;
  endtask

  typedef struct {
    logic       hinv;
    logic       vinv;
    logic [7:0] sbh;
    logic [7:0] sbv;
  } inv_vec_t;

  inv_vec_t   inv_tbl [4];
  int         n0;
  int         irq_cnt, hit_cnt, guard;
  logic [8:0] hh;

  initial begin
    inv_tbl[0] = '{hinv: 1'b0, vinv: 1'b0, sbh: 8'hA3, sbv: 8'h0C};
    inv_tbl[1] = '{hinv: 1'b1, vinv: 1'b0, sbh: 8'h5C, sbv: 8'h0C};
    inv_tbl[2] = '{hinv: 1'b0, vinv: 1'b1, sbh: 8'hA3, sbv: 8'hF3};
    inv_tbl[3] = '{hinv: 1'b1, vinv: 1'b1, sbh: 8'h5C, sbv: 8'hF3};

    RESET_n      = 1'b0;
    pix_ce       = 1'b0;
    HINV         = 1'b0;
    VINV         = 1'b0;
    Z80A_DATABUS = '0;
    scroll_wr    = '0;
    line_cmp     = 9'd300;
    model_reset();
    #12;
    check("reset_const", dut_vec, {9'd128, 8'h80, 8'h0A, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                   3'b000, 1'b0, 1'b0, 8'h00});
    check("reset_model", dut_vec, exp_vec());
    @(negedge clk);
    RESET_n = 1'b1;

    // One full line: HPIX wraps, VPIX advances exactly at HPIX 496 -> 497.
    for (int i = 0; i < 384; i++) begin
      tick(1'b1, 3'b000, 8'h00);
      if (h_of(m_n) == 9'd496) check("v_at_496", 51'(SB_V), 51'(8'h0A));
      if (h_of(m_n) == 9'd497) check("v_at_497", 51'(SB_V), 51'(8'h0B));
    end
    check("line_wrap", 51'({SB_HN, SB_V}), 51'({9'd128, 8'h0B}));

    // Scroll latch channel 1 only; the write cycle itself has no pix_ce.
    tick(1'b0, 3'b010, 8'h05);
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 3'b000, 8'h00);
      hh = h_of(m_n);
      check("snld", 51'(SNLD), 51'({hh[2:0] != 3'd0, hh[2:0] != 3'd5, hh[2:0] != 3'd0}));
    end

    // pix_ce idle; line_cmp moved onto the current line must not cause a pulse.
    n0       = m_n;
    line_cmp = v_of(m_n);
    for (int i = 0; i < 50; i++) tick(1'b0, 3'b000, 8'h00);
    check("hold", 51'({SB_HN, PH, line_hit}), 51'({h_of(n0), ph_of(n0), 1'b0}));
    line_cmp = 9'd300;

    // Table: output inversion at HPIX 0x1A3, VPIX 0x10C.
    do_reset();
    for (int i = 0; i < 1059; i++) tick(1'b1, 3'b000, 8'h00);
    for (int i = 0; i < 4; i++) begin
      HINV = inv_tbl[i].hinv;
      VINV = inv_tbl[i].vinv;
      #1;
      check("inv_tbl", 51'({SB_HN, SB_H, SB_V}), 51'({9'h1A3, inv_tbl[i].sbh, inv_tbl[i].sbv}));
    end
    HINV = 1'b0;
    VINV = 1'b0;

    // Randomised run past one full frame into the next VBL.
    do_reset();
    irq_cnt = 0;
    hit_cnt = 0;
    guard   = 0;
    while (vadv_of(m_n) < VLEN + 31 && guard < 60000) begin
      HINV = 1'($urandom_range(0, 1));
      VINV = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
           8'($urandom_range(0, 255)));
      if (vbl_irq) irq_cnt++;
      if (line_hit) hit_cnt++;
      guard++;
    end
    check("run_bound", 51'(guard < 60000), 51'(1'b1));
    check("irq_count", 51'(irq_cnt), 51'(2));
    check("hit_count", 51'(hit_cnt), 51'(1));
    check("frame_one", 51'({frame_cnt, VBL}), 51'({8'd1, 1'b1}));

    // Asynchronous reset in the middle of a low clock phase, during VBL.
    HINV = 1'b0;
    VINV = 1'b0;
    #2;
    RESET_n   = 1'b0;
    pix_ce    = 1'b0;
    scroll_wr = '0;
    model_reset();
    #1;
    check("async_rst", dut_vec, {9'd128, 8'h80, 8'h0A, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                 3'b000, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    RESET_n = 1'b1;
    irq_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1'b1, 3'b000, 8'h00);
      if (vbl_irq) irq_cnt++;
    end
    check("no_irq_after_rst", 51'(irq_cnt), 51'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
